// File: rtl/gcd_engine.sv
// gcd_engine: subtractive-Euclid GCD engine that sits downstream of the SPI
// memory-map stage. Any change on either operand starts a new computation,
// so no start strobe is needed. The result is held between computations.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   operand_a_i  first operand, level-held upstream
//   operand_b_i  second operand, level-held upstream
//   gcd_o        last completed result (registered)
//   valid_o      gcd_o matches the operand pair last captured
//   busy_o       computation in progress
//   done_o       one-cycle pulse on the edge that writes gcd_o
module gcd_engine #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic [DATA_WIDTH-1:0] gcd_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] last_a_q, last_a_d;
    logic [DATA_WIDTH-1:0] last_b_q, last_b_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] gcd_q, gcd_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  chg;

    // Compared against the snapshot, not the previous input, so rewriting
    // the same value does not restart work.
    assign chg = (operand_a_i != last_a_q) | (operand_b_i != last_b_q);

    always_comb begin
        state_d  = state_q;
        last_a_d = last_a_q;
        last_b_d = last_b_q;
        a_d      = a_q;
        b_d      = b_q;
        gcd_d    = gcd_q;
        valid_d  = valid_q;
        done_d   = 1'b0;

        // A change outranks termination, so a result for a stale pair is
        // never published.
        if (chg && (state_q == StIdle || state_q == StCalc)) begin
            last_a_d = operand_a_i;
            last_b_d = operand_b_i;
            a_d      = operand_a_i;
            b_d      = operand_b_i;
            valid_d  = 1'b0;
            state_d  = StCalc;
        end else begin
            case (state_q)
                StIdle: begin
                end
                StCalc: begin
                    if (a_q == '0) begin
                        gcd_d   = b_q;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else if (b_q == '0 || a_q == b_q) begin
                        gcd_d   = a_q;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            last_a_q <= '0;
            last_b_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            gcd_q    <= '0;
            valid_q  <= 1'b1; // gcd(0,0) = 0 is consistent with the snapshot
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gcd_q    <= gcd_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign gcd_o   = gcd_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == StCalc);

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed latency/abort/reset cases and
// a random scoreboard. A monitor samples 1 ns after each rising edge; the
// driver changes operands on falling edges.
module tb_gcd_engine;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] opa = '0;
    logic [DW-1:0] opb = '0;
    logic [DW-1:0] gcd;
    logic          valid;
    logic          busy;
    logic          done;

    int unsigned exp_q[$];
    int unsigned cap_a = 0;
    int unsigned cap_b = 0;
    int          cyc = 0;
    int          capture_cyc = 0;
    int          done_cyc = 0;
    int          done_count = 0;
    int          busy_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [DW-1:0] prev_gcd = '0;

    gcd_engine #(
        .DATA_WIDTH(DW)
    ) u_dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .operand_a_i(opa),
        .operand_b_i(opb),
        .gcd_o      (gcd),
        .valid_o    (valid),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard update for the operands now on the inputs: a new pair
    // aborts any pending result and queues the reference answer.
    task automatic apply_sb();
        if (32'(opa) != cap_a || 32'(opb) != cap_b) begin
            exp_q.delete();
            exp_q.push_back(ref_gcd(32'(opa), 32'(opb)));
            cap_a       = 32'(opa);
            cap_b       = 32'(opb);
            capture_cyc = cyc + 1;
        end
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        opa = a;
        opb = b;
        apply_sb();
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int base = done_count;
        int n = 0;
        while (done_count == base && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_count != base), 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        #2;
        while (busy && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("idle_reached", 32'(busy), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        cap_a = 0;
        cap_b = 0;
        @(posedge clk);
        #2;
        check_eq("rst_gcd", 32'(gcd), 0);
        check_eq("rst_valid", 32'(valid), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        apply_sb();
    endtask

    // Monitor: scoreboard pops, result hold and busy/valid exclusivity.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (!rst) begin
            check_eq("busy_valid_excl", 32'(busy & valid), 0);
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check_eq("done_expected", 32'(exp_q.size() != 0), 1);
                check_eq("done_valid", 32'(valid), 1);
                if (exp_q.size() != 0) check_eq("sb_gcd", 32'(gcd), exp_q.pop_front());
            end else begin
                check_eq("gcd_hold", 32'(gcd), 32'(prev_gcd));
            end
            if (valid) check_eq("valid_result", 32'(gcd), ref_gcd(cap_a, cap_b));
        end
        prev_gcd = gcd;
    end

    initial begin
        int base_busy;
        int base_done;
        int unsigned m;
        logic [DW-1:0] na;
        logic [DW-1:0] nb;

        // Reset with operands held at 0/0
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("idle_gcd", 32'(gcd), 0);
        check_eq("idle_valid", 32'(valid), 1);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_no_done", 32'(done_count), 0);

        // (12,8): result 3 edges after capture, busy for 3 cycles
        base_busy = busy_cnt;
        drive(8'd12, 8'd8);
        wait_done("g12_8", 20);
        check_eq("g12_8_latency", 32'(done_cyc - capture_cyc), 3);
        check_eq("g12_8_busy_cycles", 32'(busy_cnt - base_busy), 3);
        check_eq("g12_8_gcd", 32'(gcd), 4);
        check_eq("g12_8_busy_low", 32'(busy), 0);

        // Worst case (255,1)
        drive(8'd255, 8'd1);
        wait_done("g255_1", 300);
        check_eq("g255_1_latency", 32'(done_cyc - capture_cyc), 255);
        check_eq("g255_1_gcd", 32'(gcd), 1);

        // Zero operands terminate on the first iteration edge
        drive(8'd0, 8'd37);
        wait_done("g0_37", 10);
        check_eq("g0_37_latency", 32'(done_cyc - capture_cyc), 1);
        check_eq("g0_37_gcd", 32'(gcd), 37);
        drive(8'd37, 8'd0);
        wait_done("g37_0", 10);
        check_eq("g37_0_latency", 32'(done_cyc - capture_cyc), 1);
        check_eq("g37_0_gcd", 32'(gcd), 37);

        // Change lands on the terminating edge of (9,6)
        base_done = done_count;
        drive(8'd9, 8'd6);
        @(posedge clk); // capture
        @(posedge clk);
        @(posedge clk);
        drive(8'd9, 8'd4);
        @(posedge clk); // would-be terminating edge
        #2;
        check_eq("term_race_no_done", 32'(done), 0);
        check_eq("term_race_gcd_held", 32'(gcd), 37);
        check_eq("term_race_busy", 32'(busy), 1);
        wait_done("term_race", 50);
        repeat (3) @(posedge clk);
        #2;
        check_eq("term_race_gcd", 32'(gcd), 1);
        check_eq("term_race_one_done", 32'(done_count - base_done), 1);

        // Abort (200,3) after 10 iterations by changing b to 5
        drive(8'd200, 8'd7);
        wait_done("prep_7", 100);
        base_done = done_count;
        drive(8'd200, 8'd3);
        repeat (11) @(posedge clk);
        #2;
        check_eq("abort_gcd_held", 32'(gcd), 1);
        drive(8'd200, 8'd5);
        wait_done("abort", 100);
        repeat (3) @(posedge clk);
        #2;
        check_eq("abort_gcd", 32'(gcd), 5);
        check_eq("abort_one_done", 32'(done_count - base_done), 1);

        // Reset mid-computation, then the held operands recompute
        drive(8'd255, 8'd1);
        repeat (6) @(posedge clk);
        reset_pulse();
        wait_done("post_rst", 300);
        check_eq("post_rst_latency", 32'(done_cyc - capture_cyc), 255);
        check_eq("post_rst_gcd", 32'(gcd), 1);

        // Same-value rewrite: no recompute
        base_done = done_count;
        drive(8'd255, 8'd1);
        repeat (3) @(posedge clk);
        #2;
        check_eq("rewrite_valid", 32'(valid), 1);
        check_eq("rewrite_busy", 32'(busy), 0);
        check_eq("rewrite_no_done", 32'(done_count - base_done), 0);

        // Random scoreboard
        for (int i = 0; i < 10000; i++) begin
            m  = $urandom_range(0, 9);
            na = opa;
            nb = opb;
            case (m)
                0, 1, 2, 3, 4: begin
                    na = DW'($urandom_range(0, 255));
                    nb = DW'($urandom_range(0, 255));
                end
                5, 6: na = DW'($urandom_range(0, 255));
                7: nb = DW'($urandom_range(0, 255));
                8: ;
                default: begin
                    na = DW'($urandom_range(0, 15));
                    nb = DW'($urandom_range(0, 15));
                end
            endcase
            drive(na, nb);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                wait_idle(300);
            end else begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end
        end
        @(posedge clk);
        wait_idle(300);
        check_eq("final_valid", 32'(valid), 1);
        check_eq("final_gcd", 32'(gcd), ref_gcd(32'(opa), 32'(opb)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Subtractive-Euclid GCD engine that sits directly downstream of the SPI memory-map stage. It receives the two operand registers that the SPI stage writes and returns a held result that the SPI stage reads back. It has no start strobe. Any change on either operand input launches a new computation, so an SPI write alone is enough to trigger work. Results are held stable, and a valid flag tells the readback path whether the result matches the present operands.

## Interface
- DATA_WIDTH, 8, operand and result width in bits (must be ≥2).
- clk_i  input  1  system clock; all logic is on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- operand_a_i  input  DATA_WIDTH  first operand, level-held by the upstream register.
- operand_b_i  input  DATA_WIDTH  second operand, level-held by the upstream register.
- gcd_o  output  DATA_WIDTH  last completed result, registered.
- valid_o  output  1  high when gcd_o equals gcd(operand_a_i, operand_b_i) as last captured.
- busy_o  output  1  high while in S_CALC.
- done_o  output  1  one-cycle pulse on the edge that writes gcd_o.

## Operation
- Internal registers:
  - last_a, last_b: snapshot of the operands being or last computed.
  - a_r, b_r: working values.
- Change detect: `chg = (operand_a_i != last_a) | (operand_b_i != last_b)`, evaluated every cycle in every state.
- Reset (reset_i high at an edge):
  - state = S_IDLE.
  - last_a, last_b, a_r, b_r, gcd_o = 0.
  - valid_o = 1, because gcd(0,0) = 0 is consistent.
  - busy_o = 0, done_o = 0.
  - Reset overrides everything, including a computation in progress.
- S_IDLE:
  - If chg: last_a/a_r ← operand_a_i, last_b/b_r ← operand_b_i, valid_o ← 0, go to S_CALC.
  - Otherwise hold.
- S_CALC, in priority order, one action per edge:
  1. chg: recapture as in S_IDLE and stay in S_CALC. This is an abort/restart; no done_o, valid_o stays 0.
  2. a_r == 0: gcd_o ← b_r.
  3. b_r == 0: gcd_o ← a_r.
  4. a_r == b_r: gcd_o ← a_r.
  5. a_r > b_r: a_r ← a_r − b_r.
  6. Else: b_r ← b_r − a_r.
- Termination (rules 2–4): done_o ← 1, valid_o ← 1, go to S_IDLE.
- Arithmetic: unsigned. Subtraction never underflows because the larger operand is always the minuend. Values never grow, so no overflow is possible.
- Defined corner results: gcd(0,0) = 0, gcd(0,x) = x, gcd(x,0) = x.
- gcd_o changes only on terminating edges; it holds its old value throughout a computation and through aborts.
- Unused state encodings return to S_IDLE with valid_o = 0 and no outputs modified.

## Timing
- Capture edge: the first edge at which chg is seen. busy_o is high from the cycle after the capture edge.
- Iteration edges: each subsequent edge performs one priority step. The result appears on the terminating edge, and in the same cycle done_o is high, valid_o is high, and busy_o is low.
- Example, (12,8):
  - capture at E0;
  - E1: a = 4;
  - E2: b = 4;
  - E3: gcd_o = 4, done_o = 1.
- Latency = 1 + number of subtractions + 1 edges from the capture edge inclusive.
- Worst case: (2^W−1, 1) needs 2^W−2 subtractions, i.e. 254 for W = 8, with the result at capture + 255.
- A zero operand terminates on the first iteration edge (capture + 1).
- Operand change on the same edge as termination: the change wins. gcd_o is not updated, done_o stays 0, and a fresh computation starts.
- Both operands changing on different cycles (two SPI writes) causes at most one abort; the final result always corresponds to the last-held pair.
- Operand rewritten with the same value: chg = 0, no recompute, valid_o stays 1.

## Test plan
- Reset, then hold operands at 0/0 → gcd_o = 0, valid_o = 1, busy_o = 0, no done_o pulse.
- a = 12, b = 8 applied together → busy_o for 3 cycles; gcd_o = 4 with a done_o pulse exactly 3 edges after the capture edge; valid_o = 1.
- a = 255, b = 1 → gcd_o = 1 at capture + 255. Then a = 0, b = 37 → gcd_o = 37 at capture + 1. Then a = 37, b = 0 → gcd_o = 37.
- Abort and reset:
  - a = 200, b = 3; change b to 5 after 10 iterations → no done_o before the new result; gcd_o = 5; previous gcd_o held throughout.
  - Pulse reset_i mid-computation → all outputs return to reset values on the next edge.
- Change on the terminating edge: a = 9, b = 6 (terminates at capture + 3); at that edge drive b = 4 → no done_o at that edge, gcd_o unchanged; later gcd_o = 1 with a single done_o pulse.
- Random scoreboard: 10,000 random operand pairs with random hold times, compared against a reference gcd whenever valid_o = 1; busy_o and valid_o are never both high.
